// File: rtl/uart_reg_bridge.sv
// Host-facing command responder: decodes 'W' addr data / 'R' addr frames from the
// UART byte stream, strobes the register bus and returns one response byte.
module uart_reg_bridge #(
    parameter int unsigned TIMEOUT = 17360
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    input  logic       tx_busy_i,
    input  logic [7:0] bus_rdata_i,
    output logic       tx_start_o,
    output logic [7:0] tx_data_o,
    output logic [7:0] bus_addr_o,
    output logic [7:0] bus_wdata_o,
    output logic       bus_we_o,
    output logic       bus_re_o,
    output logic       busy_o,
    output logic       err_o
);

    localparam logic [7:0]  OP_WRITE = 8'h57;
    localparam logic [7:0]  OP_READ  = 8'h52;
    localparam logic [7:0]  RSP_OK   = 8'h4B;
    localparam logic [7:0]  RSP_BAD  = 8'h3F;
    localparam logic [15:0] TMO      = 16'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GET_DATA, DO_READ, SEND, WAIT_HI, WAIT_LO
    } state_t;

    state_t      state_q;
    logic [15:0] cnt_q, cnt_d;
    logic        is_wr_q;
    logic        rd_phase_q;
    logic        tx_start_q, bus_we_q, bus_re_q, busy_q, err_q;
    logic [7:0]  tx_data_q, bus_addr_q, bus_wdata_q;
    logic        timed_out;

    assign timed_out = (cnt_q == TMO);
    assign cnt_d     = timed_out ? cnt_q : cnt_q + 16'd1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_wr_q     <= 1'b0;
            rd_phase_q  <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_we_q    <= 1'b0;
            bus_re_q    <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            bus_we_q   <= 1'b0;
            bus_re_q   <= 1'b0;
            err_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (rx_valid_i) begin
                        busy_q <= 1'b1;
                        if (rx_data_i == OP_WRITE || rx_data_i == OP_READ) begin
                            is_wr_q <= (rx_data_i == OP_WRITE);
                            state_q <= GET_ADDR;
                        end else begin
                            tx_data_q <= RSP_BAD;
                            err_q     <= 1'b1;
                            state_q   <= SEND;
                        end
                    end
                end
                GET_ADDR: begin
                    if (rx_valid_i) begin
                        cnt_q      <= '0;
                        bus_addr_q <= rx_data_i;
                        if (is_wr_q) begin
                            state_q <= GET_DATA;
                        end else begin
                            bus_re_q   <= 1'b1;
                            rd_phase_q <= 1'b0;
                            state_q    <= DO_READ;
                        end
                    end else if (timed_out) begin
                        cnt_q   <= '0;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                GET_DATA: begin
                    if (rx_valid_i) begin
                        cnt_q       <= '0;
                        bus_wdata_q <= rx_data_i;
                        bus_we_q    <= 1'b1;
                        tx_data_q   <= RSP_OK;
                        state_q     <= SEND;
                    end else if (timed_out) begin
                        cnt_q   <= '0;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                // Read data arrives the cycle after bus_re; capture and launch together
                DO_READ: begin
                    err_q <= rx_valid_i;
                    if (!rd_phase_q) begin
                        rd_phase_q <= 1'b1;
                    end else begin
                        tx_data_q <= bus_rdata_i;
                        cnt_q     <= '0;
                        if (!tx_busy_i) begin
                            tx_start_q <= 1'b1;
                            state_q    <= WAIT_HI;
                        end else begin
                            state_q <= SEND;
                        end
                    end
                end
                SEND: begin
                    err_q <= rx_valid_i;
                    cnt_q <= '0;
                    if (!tx_busy_i) begin
                        tx_start_q <= 1'b1;
                        state_q    <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    err_q <= rx_valid_i;
                    if (tx_busy_i) begin
                        cnt_q   <= '0;
                        state_q <= WAIT_LO;
                    end else if (timed_out) begin
                        cnt_q   <= '0;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                WAIT_LO: begin
                    err_q <= rx_valid_i;
                    cnt_q <= '0;
                    if (!tx_busy_i) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx_start_o  = tx_start_q;
    assign tx_data_o   = tx_data_q;
    assign bus_addr_o  = bus_addr_q;
    assign bus_wdata_o = bus_wdata_q;
    assign bus_we_o    = bus_we_q;
    assign bus_re_o    = bus_re_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Bench for uart_reg_bridge: scripted frames, scoreboard of expected bus strobes and
// response bytes, plus cycle-exact checks on strobe/response timing.
module tb_uart_reg_bridge;

    localparam int unsigned TMO    = 40;
    localparam int          TX_LEN = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic [7:0] bus_rdata;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [7:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_we;
    logic       bus_re;
    logic       busy;
    logic       err;

    logic model_busy;
    logic hold_busy;
    assign tx_busy = model_busy | hold_busy;

    always #5 clk = ~clk;

    uart_reg_bridge #(.TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .tx_busy_i(tx_busy), .bus_rdata_i(bus_rdata),
        .tx_start_o(tx_start), .tx_data_o(tx_data),
        .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
        .bus_we_o(bus_we), .bus_re_o(bus_re),
        .busy_o(busy), .err_o(err)
    );

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } bus_exp_t;

    bus_exp_t   bus_q[$];
    logic [7:0] tx_q[$];
    logic [7:0] rd_mem [256];

    int n_checks = 0;
    int n_errors = 0;
    int n_err_pulse = 0;
    int n_we = 0;
    int n_re = 0;
    int n_tx = 0;
    logic [7:0] last_tx = 8'h00;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (err) n_err_pulse++;
        if (bus_we || bus_re) begin
            if (bus_we) n_we++;
            if (bus_re) n_re++;
            n_checks++;
            if (bus_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_strobe: we=%0b re=%0b addr=%02h, required none", bus_we, bus_re, bus_addr);
            end else begin
                bus_exp_t e;
                e = bus_q.pop_front();
                if (bus_we !== e.we || bus_re !== !e.we || bus_addr !== e.addr ||
                    (e.we && bus_wdata !== e.data)) begin
                    n_errors++;
                    $display("FAIL bus_strobe: we=%0b re=%0b addr=%02h wdata=%02h, required we=%0b addr=%02h wdata=%02h",
                             bus_we, bus_re, bus_addr, bus_wdata, e.we, e.addr, e.data);
                end
            end
        end
        if (tx_start) begin
            n_tx++;
            n_checks++;
            if (tx_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_tx_start: tx_data=%02h, required none", tx_data);
            end else begin
                logic [7:0] et;
                et = tx_q.pop_front();
                if (tx_data !== et) begin
                    n_errors++;
                    $display("FAIL tx_response: tx_data=%02h, required %02h", tx_data, et);
                end
            end
            last_tx = tx_data;
        end else if (model_busy) begin
            n_checks++;
            if (tx_data !== last_tx) begin
                n_errors++;
                $display("FAIL tx_data_stable: tx_data=%02h, required %02h", tx_data, last_tx);
            end
        end
    end

    // Transmitter model: busy rises the cycle after tx_start, lasts TX_LEN cycles
    always begin
        @(negedge clk);
        if (tx_start) begin
            @(posedge clk); #1 model_busy = 1'b1;
            repeat (TX_LEN) @(posedge clk);
            #1 model_busy = 1'b0;
        end
    end

    // Register bus read model: data valid only in the cycle after bus_re
    always begin
        @(negedge clk);
        if (bus_re) begin
            @(posedge clk); #1 bus_rdata = rd_mem[bus_addr];
            @(posedge clk); #1 bus_rdata = 8'hEE;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: sim time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1 rx_valid = 1'b1; rx_data = b;
        @(posedge clk); #1 rx_valid = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d);
        bus_q.push_back({1'b1, a, d});
        tx_q.push_back(8'h4B);
        send_byte(8'h57); send_byte(a); send_byte(d);
    endtask

    task automatic do_read(input logic [7:0] a);
        bus_q.push_back({1'b0, a, 8'h00});
        tx_q.push_back(rd_mem[a]);
        send_byte(8'h52); send_byte(a);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1;
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL wait_idle: busy=%0b after 200 cycles, required 0", busy);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({tx_start, tx_data, bus_addr, bus_wdata, bus_we, bus_re, busy, err} !== 29'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: %0h, required 0",
                     {tx_start, tx_data, bus_addr, bus_wdata, bus_we, bus_re, busy, err});
        end
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_write();
        bus_q.push_back({1'b1, 8'h10, 8'hA5});
        tx_q.push_back(8'h4B);
        send_byte(8'h57); send_byte(8'h10); send_byte(8'hA5);
        n_checks++;
        if (bus_we !== 1'b1 || bus_addr !== 8'h10 || bus_wdata !== 8'hA5 || tx_start !== 1'b0) begin
            n_errors++;
            $display("FAIL write_strobe_timing: we=%0b addr=%02h wdata=%02h txs=%0b, required 1 10 a5 0",
                     bus_we, bus_addr, bus_wdata, tx_start);
        end
        @(posedge clk); #1;
        n_checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h4B || bus_we !== 1'b0) begin
            n_errors++;
            $display("FAIL write_tx_timing: txs=%0b tx_data=%02h we=%0b, required 1 4b 0", tx_start, tx_data, bus_we);
        end
        wait_idle();
    endtask

    task automatic test_read();
        bus_q.push_back({1'b0, 8'h22, 8'h00});
        tx_q.push_back(8'h3C);
        send_byte(8'h52); send_byte(8'h22);
        n_checks++;
        if (bus_re !== 1'b1 || bus_addr !== 8'h22 || bus_we !== 1'b0) begin
            n_errors++;
            $display("FAIL read_strobe_timing: re=%0b addr=%02h we=%0b, required 1 22 0", bus_re, bus_addr, bus_we);
        end
        @(posedge clk); #1;
        n_checks++;
        if (bus_re !== 1'b0 || tx_start !== 1'b0) begin
            n_errors++;
            $display("FAIL read_gap: re=%0b txs=%0b, required 0 0", bus_re, tx_start);
        end
        @(posedge clk); #1;
        n_checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h3C) begin
            n_errors++;
            $display("FAIL read_tx_timing: txs=%0b tx_data=%02h, required 1 3c", tx_start, tx_data);
        end
        wait_idle();
    endtask

    task automatic test_unknown();
        int we0 = n_we, re0 = n_re;
        tx_q.push_back(8'h3F);
        send_byte(8'h41);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL unknown_err: err=%0b busy=%0b, required 1 1", err, busy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (tx_start !== 1'b1 || tx_data !== 8'h3F || err !== 1'b0) begin
            n_errors++;
            $display("FAIL unknown_tx: txs=%0b tx_data=%02h err=%0b, required 1 3f 0", tx_start, tx_data, err);
        end
        wait_idle();
        n_checks++;
        if (n_we != we0 || n_re != re0) begin
            n_errors++;
            $display("FAIL unknown_no_strobe: we=%0d re=%0d, required %0d %0d", n_we, n_re, we0, re0);
        end
    endtask

    task automatic test_timeout();
        int tx0 = n_tx, we0 = n_we, e0 = n_err_pulse;
        send_byte(8'h57); send_byte(8'h10);
        repeat (TMO) @(posedge clk);
        #1;
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_early: err=%0b busy=%0b, required 0 1", err, busy);
        end
        @(posedge clk); #1;
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_fire: err=%0b busy=%0b, required 1 0", err, busy);
        end
        repeat (3) @(posedge clk);
        n_checks++;
        if (n_tx != tx0 || n_we != we0 || n_err_pulse != e0 + 1) begin
            n_errors++;
            $display("FAIL timeout_effects: tx=%0d we=%0d errs=%0d, required %0d %0d %0d",
                     n_tx, n_we, n_err_pulse, tx0, we0, e0 + 1);
        end
        do_write(8'h33, 8'h5A);
        wait_idle();
        n_checks++;
        if (n_we != we0 + 1 || n_tx != tx0 + 1) begin
            n_errors++;
            $display("FAIL timeout_recover: we=%0d tx=%0d, required %0d %0d", n_we, n_tx, we0 + 1, tx0 + 1);
        end
    endtask

    task automatic test_byte_during_response();
        int tx0 = n_tx, e0;
        hold_busy = 1'b1;
        do_write(8'h44, 8'hC3);
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (n_tx != tx0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL held_no_tx: tx=%0d busy=%0b, required %0d 1", n_tx, busy, tx0);
        end
        e0 = n_err_pulse;
        send_byte(8'h55);
        n_checks++;
        if (err !== 1'b1 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL drop_err: err=%0b busy=%0b, required 1 1", err, busy);
        end
        repeat (3) @(posedge clk);
        #1 hold_busy = 1'b0;
        wait_idle();
        n_checks++;
        if (n_tx != tx0 + 1 || n_err_pulse != e0 + 1) begin
            n_errors++;
            $display("FAIL drop_response: tx=%0d errs=%0d, required %0d %0d", n_tx, n_err_pulse, tx0 + 1, e0 + 1);
        end
    endtask

    task automatic test_back_to_back();
        int tx0 = n_tx;
        do_write(8'h50, 8'h11);
        wait_idle();
        do_read(8'h07);
        wait_idle();
        do_write(8'hFF, 8'h00);
        wait_idle();
        do_read(8'hC8);
        wait_idle();
        n_checks++;
        if (n_tx != tx0 + 4) begin
            n_errors++;
            $display("FAIL back_to_back: tx=%0d, required %0d", n_tx, tx0 + 4);
        end
    endtask

    task automatic test_reset_abort();
        int re0 = n_re, tx0 = n_tx;
        @(posedge clk); #1 rx_valid = 1'b1; rx_data = 8'h52;
        @(posedge clk); #1 rx_data = 8'h22;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({tx_start, tx_data, bus_addr, bus_wdata, bus_we, bus_re, busy, err} !== 29'd0) begin
            n_errors++;
            $display("FAIL abort_outputs: %0h, required 0",
                     {tx_start, tx_data, bus_addr, bus_wdata, bus_we, bus_re, busy, err});
        end
        @(posedge clk); #1 rx_valid = 1'b0; rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (n_re != re0 || n_tx != tx0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_quiet: re=%0d tx=%0d busy=%0b, required %0d %0d 0", n_re, n_tx, busy, re0, tx0);
        end
        do_read(8'h22);
        wait_idle();
    endtask

    initial begin
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        hold_busy = 1'b0;
        model_busy = 1'b0;
        bus_rdata = 8'hEE;
        for (int i = 0; i < 256; i++) rd_mem[i] = 8'(i) ^ 8'h5A;
        rd_mem[8'h22] = 8'h3C;

        test_reset();
        test_write();
        test_read();
        test_unknown();
        test_timeout();
        test_byte_during_response();
        test_back_to_back();
        test_reset_abort();

        repeat (5) @(posedge clk);
        n_checks++;
        if (bus_q.size() != 0 || tx_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: bus=%0d tx=%0d pending, required 0 0", bus_q.size(), tx_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_reg_bridge.md
# uart_reg_bridge

Byte-level command responder between the UART byte interface and an 8-bit register bus. It decodes read and write frames from the UART receive-byte stream, issues single-cycle register bus strobes, and returns one response byte through the UART transmit handshake. It is the host-facing end of the UART link, letting a PC peek and poke FPGA registers.

## Interface
- `TIMEOUT`, default 17360: maximum number of idle clocks allowed between bytes of one frame, and the maximum wait for `tx_busy` to rise. The default is 4 byte-times at 434 clk/bit. The counter is 16 bits wide.
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `rx_valid` in 1: one-cycle pulse; `rx_data` holds a received byte.
- `rx_data` in 8: received byte.
- `tx_busy` in 1: the transmitter is sending. It rises the cycle after `tx_start` is accepted.
- `tx_start` out 1: one-cycle request to transmit `tx_data`.
- `tx_data` out 8: response byte. It is stable from `tx_start` until `tx_busy` falls.
- `bus_addr` out 8: register address.
- `bus_wdata` out 8: write data.
- `bus_we` out 1: one-cycle write strobe.
- `bus_re` out 1: one-cycle read strobe.
- `bus_rdata` in 8: read data, valid the cycle after `bus_re`.
- `busy` out 1: high in every state except IDLE.
- `err` out 1: one-cycle error pulse.

## Operation
- All outputs are registered.
- Reset values: every output is 0, including `tx_data`, `bus_addr` and `bus_wdata`. The state is IDLE and the timeout counter is 0.
- Frames:
  - Write: 0x57 ('W'), addr, data. Response is 0x4B ('K').
  - Read: 0x52 ('R'), addr. Response is the read data byte.
- States: IDLE, GET_ADDR, GET_DATA, DO_READ, SEND, WAIT_HI, WAIT_LO.
- IDLE, on `rx_valid`:
  - 0x57 or 0x52: latch the opcode and go to GET_ADDR.
  - Any other byte: set `tx_data`=0x3F ('?'), pulse `err`, go to SEND.
- GET_ADDR, on `rx_valid`: latch `bus_addr`.
  - Write: go to GET_DATA.
  - Read: assert `bus_re` for one cycle and go to DO_READ.
- GET_DATA, on `rx_valid`: latch `bus_wdata`, assert `bus_we` for one cycle, set `tx_data`=0x4B, go to SEND.
- DO_READ: capture `bus_rdata` into `tx_data` and go to SEND.
- SEND: if `tx_busy`=0, pulse `tx_start` and go to WAIT_HI. Otherwise stay in SEND.
- WAIT_HI: on `tx_busy`=1, go to WAIT_LO.
- WAIT_LO: on `tx_busy`=0, go to IDLE.
- Timeout counter:
  - Clears on entry to each state and on every accepted `rx_valid`.
  - Increments in GET_ADDR, GET_DATA and WAIT_HI, saturating at `TIMEOUT`.
  - Reaching `TIMEOUT` in GET_ADDR or GET_DATA: pulse `err`, go to IDLE, no response, no bus strobe.
  - Reaching `TIMEOUT` in WAIT_HI: pulse `err`, go to IDLE.
- `rx_valid` in DO_READ, SEND, WAIT_HI or WAIT_LO: the byte is dropped and `err` pulses. The state is unaffected.
- `bus_we` and `bus_re` are never both high. Each is at most one cycle per frame.
- Reset mid-operation aborts immediately: no strobe, no `tx_start`, partial frame discarded.

## Timing
- Write: final `rx_valid` in cycle N.
  - `bus_we`, `bus_addr` and `bus_wdata` are valid in cycle N+1.
  - `tx_start` is high in cycle N+2 if `tx_busy`=0.
- Read: address `rx_valid` in cycle N.
  - `bus_re` is high in N+1.
  - `bus_rdata` is sampled at the end of N+2.
  - `tx_start` is high in N+3 if `tx_busy`=0.
- Unknown opcode in cycle N: `err` high in N+1, `tx_start` high in N+2.
- `busy` rises the cycle after the first accepted byte. It falls the cycle after `tx_busy` falls in WAIT_LO.
- Back-to-back frames are accepted from the first cycle `busy`=0.

## Test plan
- Write: send 0x57, 0x10, 0xA5 with idle `tx_busy` -> `bus_we` one cycle with addr 0x10 and wdata 0xA5, then `tx_start` with `tx_data`=0x4B.
- Read: send 0x52, 0x22; `bus_rdata`=0x3C the cycle after `bus_re` -> `bus_re` one cycle with addr 0x22, then `tx_start` with `tx_data`=0x3C.
- Unknown opcode 0x41 -> `err` pulse, `tx_data`=0x3F, `tx_start`, no bus strobe.
- Timeout: send 0x57, 0x10, then nothing for `TIMEOUT` cycles -> `err` pulse, return to IDLE, no `bus_we`, no `tx_start`. A following full write frame completes normally.
- Byte during response: hold `tx_busy` high while the response is pending and inject `rx_valid` 0x55 -> `err` pulse, byte ignored, the single response is still sent after `tx_busy` falls.
- Reset after 0x52, 0x22 while `bus_re` is pending -> all outputs 0 the next cycle, `bus_re` never asserted, `busy`=0.
